// File: rtl/if_bus_if.sv
// if_bus_if -- instruction-fetch bus master.
// Routes the IF-stage fetch either to the scratch-pad memory (same-cycle) or to
// the shared bus (request/grant, one-cycle address strobe, ready handshake),
// and drives `busy` into the pipeline stall path while a bus fetch is pending.
// Optional feature: define IF_BUS_TIMEOUT_EN to enable an ACCESS-state watchdog
// that abandons a bus fetch after TIMEOUT_CYCLES cycles and pulses bus_err.
module if_bus_if #(
   parameter int                ADDR_W         = 30,
   parameter int                DATA_W         = 32,
   parameter int                SEG_W          = 3,
   parameter logic [SEG_W-1:0]  SPM_SEG        = 3'b011,
   parameter int                TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              as_,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic [ADDR_W-1:0] spm_addr,
   output logic              spm_as_,
   input  logic [DATA_W-1:0] spm_rd_data,
   output logic              bus_req_,
   input  logic              bus_grnt_,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_as_,
   output logic              bus_rw,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_,
   output logic              bus_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      ACCESS = 2'd2,
      WAIT   = 2'd3
   } state_t;

   localparam logic [DATA_W-1:0] NOP = '0;

   state_t            state;
   logic [DATA_W-1:0] rd_buf;
   logic              discard;
   logic              spm_hit;
   logic              timeout;
   logic              drop_data;

   // The SPM sees the fetch address directly; only the strobe is qualified.
   assign spm_addr  = addr;
   assign spm_hit   = (addr[ADDR_W-1 -: SEG_W] == SPM_SEG);
   // A flush in the rdy cycle itself counts just like one in an earlier cycle.
   assign drop_data = discard | flush;
   // This master never writes.
   assign bus_rw    = 1'b1;

`ifdef IF_BUS_TIMEOUT_EN
   logic [7:0] to_cnt;

   assign timeout = (state == ACCESS) && bus_rdy_ &&
                    (to_cnt == 8'(TIMEOUT_CYCLES - 1));

   // Watchdog: count ACCESS cycles without rdy; pulse bus_err after giving up.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt  <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= timeout;
         if (state == REQ && !flush && !bus_grnt_)
            to_cnt <= '0;
         else if (state == ACCESS && bus_rdy_ && !timeout)
            to_cnt <= to_cnt + 8'd1;
      end
   end
`else
   assign timeout = 1'b0;
   assign bus_err = 1'b0;
`endif

   // Fetch result and stall request, decoded from state and live inputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // (an unassigned path in always_comb would infer a latch).
      rd_data = NOP;
      busy    = 1'b0;
      spm_as_ = 1'b1;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (!flush && !as_) begin
                  if (spm_hit) begin
                     spm_as_ = 1'b0;
                     rd_data = spm_rd_data;
                  end else begin
                     busy = 1'b1;
                  end
               end
            end
            REQ: begin
               busy = 1'b1;
            end
            ACCESS: begin
               if (!bus_rdy_) begin
                  if (!drop_data)
                     rd_data = bus_rd_data;
               end else if (!timeout) begin
                  busy = 1'b1;
               end
            end
            WAIT: begin
               if (!flush)
                  rd_data = rd_buf;
            end
            default: ;
         endcase
      end
   end

   // Bus-side FSM with registered request, strobe and address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         bus_req_ <= 1'b1;
         bus_as_  <= 1'b1;
         bus_addr <= '0;
         rd_buf   <= '0;
         discard  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // samples pre-edge values regardless of statement order.
         bus_as_ <= 1'b1;
         case (state)
            IDLE: begin
               if (!flush && !as_ && !spm_hit) begin
                  bus_req_ <= 1'b0;
                  bus_addr <= addr;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (flush) begin
                  bus_req_ <= 1'b1;
                  state    <= IDLE;
               end else if (!bus_grnt_) begin
                  bus_as_ <= 1'b0;
                  discard <= 1'b0;
                  state   <= ACCESS;
               end
            end
            ACCESS: begin
               if (!bus_rdy_) begin
                  rd_buf   <= bus_rd_data;
                  bus_req_ <= 1'b1;
                  discard  <= 1'b0;
                  state    <= (stall && !drop_data) ? WAIT : IDLE;
               end else if (timeout) begin
                  bus_req_ <= 1'b1;
                  discard  <= 1'b0;
                  state    <= IDLE;
               end else if (flush) begin
                  // The bus cannot abort a transfer; remember to drop its data.
                  discard <= 1'b1;
               end
            end
            WAIT: begin
               if (flush || !stall)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_bus_if.sv
// tb_if_bus_if -- directed self-checking bench for if_bus_if.
// Inputs change 1 time unit after the rising edge; outputs are checked 3 units
// after the edge, well clear of it.
module tb_if_bus_if;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] addr;
   logic        as_;
   logic        stall;
   logic        flush;
   logic [31:0] rd_data;
   logic        busy;
   logic [29:0] spm_addr;
   logic        spm_as_;
   logic [31:0] spm_rd_data;
   logic        bus_req_;
   logic        bus_grnt_;
   logic [29:0] bus_addr;
   logic        bus_as_;
   logic        bus_rw;
   logic [31:0] bus_rd_data;
   logic        bus_rdy_;
   logic        bus_err;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   if_bus_if #(.TIMEOUT_CYCLES(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .addr        (addr),
      .as_         (as_),
      .stall       (stall),
      .flush       (flush),
      .rd_data     (rd_data),
      .busy        (busy),
      .spm_addr    (spm_addr),
      .spm_as_     (spm_as_),
      .spm_rd_data (spm_rd_data),
      .bus_req_    (bus_req_),
      .bus_grnt_   (bus_grnt_),
      .bus_addr    (bus_addr),
      .bus_as_     (bus_as_),
      .bus_rw      (bus_rw),
      .bus_rd_data (bus_rd_data),
      .bus_rdy_    (bus_rdy_),
      .bus_err     (bus_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      // ---- reset: outputs idle even with an SPM fetch requested ----
      reset       = 1'b1;
      addr        = 30'h1800_0004;
      as_         = 1'b0;
      stall       = 1'b0;
      flush       = 1'b0;
      spm_rd_data = 32'hA5A5_0001;
      bus_grnt_   = 1'b1;
      bus_rd_data = 32'h0;
      bus_rdy_    = 1'b1;
      #3;
      check("rst_busy", busy, 0);
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_spm_as_", spm_as_, 1);
      check("rst_bus_req_", bus_req_, 1);
      check("rst_bus_as_", bus_as_, 1);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_err", bus_err, 0);
      check("rst_bus_rw", bus_rw, 1);

      // ---- SPM hit: same-cycle data, no bus request ----
      tick(); reset = 1'b0; settle();
      check("spm_rd_data", rd_data, 32'hA5A5_0001);
      check("spm_busy", busy, 0);
      check("spm_as_", spm_as_, 0);
      check("spm_addr", spm_addr, 30'h1800_0004);
      check("spm_bus_req_", bus_req_, 1);
      tick(); spm_rd_data = 32'h0BAD_F00D; settle();
      check("spm2_rd_data", rd_data, 32'h0BAD_F00D);
      check("spm2_bus_req_", bus_req_, 1);
      as_ = 1'b1; #1;
      check("idle_as_hi_rd_data", rd_data, 32'h0);
      check("idle_as_hi_spm_as_", spm_as_, 1);

      // ---- bus fetch: grant in 2nd REQ cycle, rdy in 2nd ACCESS cycle ----
      tick(); addr = 30'h10; as_ = 1'b0; bus_rd_data = 32'h1234_5678; settle();
      check("f1_idle_busy", busy, 1);
      check("f1_idle_rd_data", rd_data, 32'h0);
      check("f1_idle_bus_req_", bus_req_, 1);
      tick(); as_ = 1'b1; settle();
      check("f1_req1_busy", busy, 1);
      check("f1_req1_bus_req_", bus_req_, 0);
      check("f1_req1_bus_addr", bus_addr, 30'h10);
      check("f1_req1_bus_as_", bus_as_, 1);
      tick(); bus_grnt_ = 1'b0; settle();
      check("f1_req2_busy", busy, 1);
      tick(); bus_grnt_ = 1'b1; settle();
      check("f1_acc1_bus_as_", bus_as_, 0);
      check("f1_acc1_bus_addr", bus_addr, 30'h10);
      check("f1_acc1_busy", busy, 1);
      tick(); bus_rdy_ = 1'b0; settle();
      check("f1_rdy_bus_as_", bus_as_, 1);
      check("f1_rdy_rd_data", rd_data, 32'h1234_5678);
      check("f1_rdy_busy", busy, 0);
      check("f1_rdy_bus_req_", bus_req_, 0);
      tick(); bus_rdy_ = 1'b1; settle();
      check("f1_done_bus_req_", bus_req_, 1);
      check("f1_done_busy", busy, 0);
      check("f1_done_rd_data", rd_data, 32'h0);

      // ---- bus fetch with stall on the rdy cycle: held in WAIT ----
      tick(); addr = 30'h20; as_ = 1'b0; settle();
      tick(); as_ = 1'b1; bus_grnt_ = 1'b0; settle();
      check("f2_req_busy", busy, 1);
      tick(); bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; stall = 1'b1; settle();
      check("f2_rdy_rd_data", rd_data, 32'h1234_5678);
      check("f2_rdy_busy", busy, 0);
      tick(); bus_rdy_ = 1'b1; bus_rd_data = 32'hDEAD_BEEF; settle();
      check("f2_wait1_rd_data", rd_data, 32'h1234_5678);
      check("f2_wait1_busy", busy, 0);
      check("f2_wait1_bus_req_", bus_req_, 1);
      check("f2_wait1_bus_addr", bus_addr, 30'h20);
      tick(); settle();
      check("f2_wait2_rd_data", rd_data, 32'h1234_5678);
      tick(); stall = 1'b0; settle();
      check("f2_wait3_rd_data", rd_data, 32'h1234_5678);
      check("f2_wait3_busy", busy, 0);
      tick(); settle();
      check("f2_idle_rd_data", rd_data, 32'h0);
      check("f2_idle_busy", busy, 0);

      // ---- flush in ACCESS: data dropped when rdy arrives 2 cycles later ----
      tick(); addr = 30'h30; as_ = 1'b0; settle();
      tick(); as_ = 1'b1; bus_grnt_ = 1'b0; settle();
      tick(); bus_grnt_ = 1'b1; flush = 1'b1; settle();
      check("f3_acc1_busy", busy, 1);
      check("f3_acc1_rd_data", rd_data, 32'h0);
      tick(); flush = 1'b0; settle();
      check("f3_acc2_busy", busy, 1);
      tick(); bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFE_F00D; settle();
      check("f3_rdy_rd_data", rd_data, 32'h0);
      check("f3_rdy_busy", busy, 0);
      tick(); bus_rdy_ = 1'b1; settle();
      check("f3_done_bus_req_", bus_req_, 1);
      check("f3_done_rd_data", rd_data, 32'h0);
      check("f3_done_busy", busy, 0);

      // ---- flush in REQ: request withdrawn, no strobe ----
      tick(); addr = 30'h40; as_ = 1'b0; settle();
      tick(); as_ = 1'b1; flush = 1'b1; settle();
      check("f4_req_bus_req_", bus_req_, 0);
      tick(); flush = 1'b0; bus_grnt_ = 1'b0; settle();
      check("f4_idle_bus_req_", bus_req_, 1);
      check("f4_idle_bus_as_", bus_as_, 1);
      check("f4_idle_busy", busy, 0);
      tick(); bus_grnt_ = 1'b1; settle();
      check("f4_idle2_bus_as_", bus_as_, 1);

      // ---- plain fetch after a discard: data delivered normally ----
      tick(); addr = 30'h50; as_ = 1'b0; bus_rd_data = 32'h0F0F_0F0F; settle();
      tick(); as_ = 1'b1; bus_grnt_ = 1'b0; settle();
      tick(); bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; settle();
      check("f5_rdy_rd_data", rd_data, 32'h0F0F_0F0F);
      check("f5_rdy_busy", busy, 0);
      tick(); bus_rdy_ = 1'b1; settle();

      // ---- asynchronous reset while in ACCESS ----
      tick(); addr = 30'h60; as_ = 1'b0; settle();
      tick(); as_ = 1'b1; bus_grnt_ = 1'b0; settle();
      tick(); bus_grnt_ = 1'b1; settle();
      check("f6_acc_bus_as_", bus_as_, 0);
      check("f6_acc_bus_req_", bus_req_, 0);
      reset = 1'b1; #1;
      check("f6_rst_bus_req_", bus_req_, 1);
      check("f6_rst_bus_as_", bus_as_, 1);
      check("f6_rst_busy", busy, 0);
      check("f6_rst_rd_data", rd_data, 32'h0);
      check("f6_rst_bus_addr", bus_addr, 0);
      tick(); reset = 1'b0; settle();
      check("f6_post_busy", busy, 0);
      check("f6_post_bus_req_", bus_req_, 1);

      // ---- flush in IDLE suppresses a non-SPM request ----
      tick(); addr = 30'h70; as_ = 1'b0; flush = 1'b1; settle();
      check("f7_idle_busy", busy, 0);
      check("f7_idle_rd_data", rd_data, 32'h0);
      tick(); as_ = 1'b1; flush = 1'b0; settle();
      check("f7_next_bus_req_", bus_req_, 1);

`ifdef IF_BUS_TIMEOUT_EN
      // ---- watchdog: rdy never arrives, give up after 4 ACCESS cycles ----
      tick(); addr = 30'h80; as_ = 1'b0; settle();
      tick(); as_ = 1'b1; bus_grnt_ = 1'b0; settle();
      tick(); bus_grnt_ = 1'b1; settle();
      check("to_acc1_busy", busy, 1);
      tick(); settle();
      check("to_acc2_busy", busy, 1);
      tick(); settle();
      check("to_acc3_busy", busy, 1);
      check("to_acc3_bus_err", bus_err, 0);
      tick(); settle();
      check("to_acc4_busy", busy, 0);
      check("to_acc4_rd_data", rd_data, 32'h0);
      tick(); settle();
      check("to_err_bus_err", bus_err, 1);
      check("to_err_bus_req_", bus_req_, 1);
      check("to_err_busy", busy, 0);
      check("to_err_rd_data", rd_data, 32'h0);
      tick(); settle();
      check("to_after_bus_err", bus_err, 0);
`else
      // ---- without the watchdog bus_err never asserts ----
      check("no_to_bus_err", bus_err, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
